matmul_sequencer: RTL and testbench

- Control sequencer that sits directly upstream of the systolic-array top level and drives its fill_fifo, drain_fifo and active strobes and its per-lane base addresses.
- Runs one complete job per host start:
  - loads one weight tile: memory to FIFO, then FIFO to array;
  - streams num_tiles input tiles through the array;
  - waits on the three done signals between phases.
- Replaces host-CPU bit-banging of those strobes. Adds per-phase timeout detection.

---
 rtl/matmul_sequencer.sv | 127 ++++++++++++
 tb/tb_matmul_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: job sequencer driving fill/drain/active strobes and lane base addresses of the systolic array
//   clk, reset (async, active-high); start + num_tiles/weight_base/input_base/output_base job request
//   mem_to_fifo_done, fifo_to_arr_done, output_done: phase completion from the array top
//   fill_fifo, drain_fifo, active: 1-cycle strobes; *_addr_base: per-lane replicated bases
//   tile_idx, busy, done (pulse), error (sticky timeout)
module matmul_sequencer #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [7:0] num_tiles,
  input  logic [7:0] weight_base,
  input  logic [7:0] input_base,
  input  logic [7:0] output_base,
  input  logic mem_to_fifo_done,
  input  logic fifo_to_arr_done,
  input  logic output_done,
  output logic fill_fifo,
  output logic drain_fifo,
  output logic active,
  output logic [WIDTH_HEIGHT*8-1:0] weightMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*8-1:0] inputMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*8-1:0] outputMem_wr_addr_base,
  output logic [7:0] tile_idx,
  output logic busy,
  output logic done,
  output logic error
);
  typedef enum logic [3:0] {IDLE, FILL, FILL_WAIT, DRAIN, DRAIN_WAIT, COMPUTE, COMPUTE_WAIT, NEXT, FINISH, ERR} state_t;
  localparam logic [7:0] STEP = 8'(WIDTH_HEIGHT);
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state;
  logic [7:0] n_tiles, w_base, in_base, out_base;
  logic [15:0] cnt;
  logic wait_done;
  assign weightMem_rd_addr_base = {WIDTH_HEIGHT{w_base}};
  assign inputMem_rd_addr_base = {WIDTH_HEIGHT{in_base}};
  assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base}};
  always_comb
    wait_done = state == FILL_WAIT ? mem_to_fifo_done :
                state == DRAIN_WAIT ? fifo_to_arr_done :
                state == COMPUTE_WAIT ? output_done : 1'b0;
  // Strobes, done and busy are registered alongside the state they belong to,
  // so each is set on the transition into its state and cleared by default.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      n_tiles <= '0;
      w_base <= '0;
      in_base <= '0;
      out_base <= '0;
      cnt <= '0;
      tile_idx <= '0;
      fill_fifo <= 1'b0;
      drain_fifo <= 1'b0;
      active <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      fill_fifo <= 1'b0;
      drain_fifo <= 1'b0;
      active <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, ERR: if (start) begin
          n_tiles <= num_tiles;
          w_base <= weight_base;
          in_base <= input_base;
          out_base <= output_base;
          tile_idx <= '0;
          error <= 1'b0;
          busy <= 1'b1;
          state <= num_tiles != 8'd0 ? FILL : FINISH;
          fill_fifo <= num_tiles != 8'd0;
          done <= num_tiles == 8'd0;
        end
        FILL: begin
          state <= FILL_WAIT;
          cnt <= '0;
        end
        DRAIN: begin
          state <= DRAIN_WAIT;
          cnt <= '0;
        end
        COMPUTE: begin
          state <= COMPUTE_WAIT;
          cnt <= '0;
        end
        FILL_WAIT, DRAIN_WAIT, COMPUTE_WAIT: begin
          if (wait_done) begin
            state <= state == FILL_WAIT ? DRAIN : state == DRAIN_WAIT ? COMPUTE : NEXT;
            drain_fifo <= state == FILL_WAIT;
            active <= state == DRAIN_WAIT;
          end else if (cnt == LAST) begin
            state <= ERR;
            error <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // Bases advance by one array width per tile; 8-bit wrap is intended.
        NEXT: if (tile_idx == n_tiles - 8'd1) begin
          state <= FINISH;
          done <= 1'b1;
        end else begin
          tile_idx <= tile_idx + 8'd1;
          in_base <= in_base + STEP;
          out_base <= out_base + STEP;
          state <= COMPUTE;
          active <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench for matmul_sequencer with echoing done inputs
module tb_matmul_sequencer;
  localparam int WH = 16;
  logic clk, reset, start;
  logic [7:0] num_tiles, weight_base, input_base, output_base;
  logic mem_to_fifo_done, fifo_to_arr_done, output_done;
  logic fill_fifo, drain_fifo, active, busy, done, error;
  logic [WH*8-1:0] w_bus, in_bus, out_bus;
  logic [7:0] tile_idx;
  int tests, fails, cyc, f2a_lat, d_age;
  int n_fill, n_drain, n_act, n_done, n_busy, bad;
  int f_cyc, d_cyc, a_cyc, done_cyc, b_first, b_last, e_cyc;
  logic p_fill, p_drain, p_act;
  logic [127:0] in_log [8];
  logic [127:0] out_log [8];
  logic [7:0] idx_log [8];

  matmul_sequencer #(.WIDTH_HEIGHT(WH), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .weight_base(weight_base), .input_base(input_base), .output_base(output_base),
    .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done), .output_done(output_done),
    .fill_fifo(fill_fifo), .drain_fifo(drain_fifo), .active(active),
    .weightMem_rd_addr_base(w_bus), .inputMem_rd_addr_base(in_bus), .outputMem_wr_addr_base(out_bus),
    .tile_idx(tile_idx), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cyc = 0; n_fill = 0; n_drain = 0; n_act = 0; n_done = 0; n_busy = 0; bad = 0;
    f_cyc = -1; d_cyc = -1; a_cyc = -1; done_cyc = -1; b_first = -1; b_last = -1; e_cyc = -1;
  endtask

  // One clock: drive echoed done inputs for the new cycle, then log what the DUT shows in it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    d_age = p_drain ? 1 : d_age + 1;
    mem_to_fifo_done = p_fill;
    fifo_to_arr_done = (d_age == f2a_lat);
    output_done = p_act;
    if ((int'(fill_fifo) + int'(drain_fifo) + int'(active) > 1) ||
        ((fill_fifo | drain_fifo | active) && (p_fill | p_drain | p_act))) bad++;
    if (fill_fifo) begin n_fill++; f_cyc = cyc; end
    if (drain_fifo) begin n_drain++; d_cyc = cyc; end
    if (active) begin
      if (n_act < 8) begin
        in_log[n_act] = in_bus; out_log[n_act] = out_bus; idx_log[n_act] = tile_idx;
      end
      if (n_act == 0) a_cyc = cyc;
      n_act++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) begin n_busy++; if (b_first < 0) b_first = cyc; b_last = cyc; end
    if (error && e_cyc < 0) e_cyc = cyc;
    p_fill = fill_fifo; p_drain = drain_fifo; p_act = active;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_job(input logic [7:0] nt, input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob);
    num_tiles = nt; weight_base = wb; input_base = ib; output_base = ob;
    start = 1'b1;
    clear_counts();
    tick();
    start = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; f2a_lat = 1; d_age = 100;
    p_fill = 0; p_drain = 0; p_act = 0;
    reset = 1'b1; start = 1'b0;
    num_tiles = 0; weight_base = 0; input_base = 0; output_base = 0;
    mem_to_fifo_done = 0; fifo_to_arr_done = 0; output_done = 0;
    clear_counts();
    run(3);
    chk("rst_strobes", {fill_fifo, drain_fifo, active}, 0);
    chk("rst_flags", {busy, done, error}, 0);
    chk("rst_tile_idx", tile_idx, 0);
    chk("rst_in_bus", in_bus, 0);
    reset = 1'b0;
    run(2);

    start_job(8'd1, 8'h00, 8'h00, 8'h00);
    run(11);
    chk("t1_fill_cyc", f_cyc, 1);
    chk("t1_drain_cyc", d_cyc, 3);
    chk("t1_active_cyc", a_cyc, 5);
    chk("t1_done_cyc", done_cyc, 8);
    chk("t1_busy_first", b_first, 1);
    chk("t1_busy_last", b_last, 8);
    chk("t1_busy_cnt", n_busy, 8);
    chk("t1_pulses", {8'(n_fill), 8'(n_drain), 8'(n_act), 8'(n_done)}, 32'h01010101);
    chk("t1_strobe_excl", bad, 0);

    start_job(8'd3, 8'h05, 8'h10, 8'h20);
    run(14);
    chk("t2_active_cnt", n_act, 3);
    chk("t2_fill_drain", {8'(n_fill), 8'(n_drain)}, 16'h0101);
    chk("t2_in0", in_log[0], {WH{8'h10}});
    chk("t2_in1", in_log[1], {WH{8'h20}});
    chk("t2_in2", in_log[2], {WH{8'h30}});
    chk("t2_out0", out_log[0], {WH{8'h20}});
    chk("t2_out1", out_log[1], {WH{8'h30}});
    chk("t2_out2", out_log[2], {WH{8'h40}});
    chk("t2_idx", {idx_log[0], idx_log[1], idx_log[2]}, 24'h000102);
    chk("t2_weight_bus", w_bus, {WH{8'h05}});
    chk("t2_done_cyc", done_cyc, 14);
    chk("t2_strobe_excl", bad, 0);

    start_job(8'd2, 8'h00, 8'hF0, 8'h00);
    run(11);
    chk("t3_in0", in_log[0], {WH{8'hF0}});
    chk("t3_in1_wrap", in_log[1], {WH{8'h00}});
    chk("t3_done_cyc", done_cyc, 11);

    start_job(8'd0, 8'h00, 8'h00, 8'h00);
    run(3);
    chk("t4_no_strobes", n_fill + n_drain + n_act, 0);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_busy_cnt", n_busy, 1);
    chk("t4_busy_first", b_first, 1);

    f2a_lat = 0;
    start_job(8'd1, 8'h00, 8'h00, 8'h00);
    run(14);
    chk("t5_err_cyc", e_cyc, 12);
    chk("t5_no_active", n_act, 0);
    chk("t5_no_done", n_done, 0);
    chk("t5_busy_err", {busy, error}, 2'b01);
    f2a_lat = 1;
    start_job(8'd1, 8'h00, 8'h00, 8'h00);
    chk("t5_err_cleared", error, 0);
    run(9);
    chk("t5_rerun_done", done_cyc, 8);
    chk("t5_rerun_err", error, 0);

    f2a_lat = 8;
    start_job(8'd1, 8'h00, 8'h00, 8'h00);
    run(16);
    chk("t6_last_cycle_done", done_cyc, 15);
    chk("t6_no_err", {8'(n_act), 7'd0, error}, 16'h0100);
    f2a_lat = 1;

    start_job(8'd4, 8'h01, 8'h02, 8'h03);
    for (int i = 0; i < 20 && n_act < 2; i++) tick();
    chk("t7_reached_tile1", n_act, 2);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t7_async_strobes", {fill_fifo, drain_fifo, active}, 0);
    chk("t7_async_flags", {busy, done, error}, 0);
    chk("t7_async_idx", tile_idx, 0);
    chk("t7_async_buses", w_bus | in_bus | out_bus, 0);
    tick();
    reset = 1'b0;
    clear_counts();
    run(12);
    chk("t7_no_strobes", n_fill + n_drain + n_act, 0);
    chk("t7_idle", {8'(n_busy), 8'(n_done)}, 0);

    f2a_lat = 3;
    start_job(8'd1, 8'h11, 8'h22, 8'h33);
    run(3);
    num_tiles = 8'd5; weight_base = 8'h99; input_base = 8'h98; output_base = 8'h97;
    start = 1'b1;
    tick();
    start = 1'b0;
    run(8);
    chk("t8_done_cyc", done_cyc, 10);
    chk("t8_single_job", {8'(n_fill), 8'(n_act), 8'(n_done)}, 24'h010101);
    chk("t8_in_at_active", in_log[0], {WH{8'h22}});
    chk("t8_w_bus", w_bus, {WH{8'h11}});
    chk("t8_in_bus", in_bus, {WH{8'h22}});
    chk("t8_out_bus", out_bus, {WH{8'h33}});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
